// File: rtl/sipo_frame_receiver.sv
// Serial-in/parallel-out frame receiver with a valid/ready output register.
// Optional PARITY_CHECK_EN: appends an even-parity bit to each frame and adds parity_error_o.
module sipo_frame_receiver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             serial_in_i,
  input  logic             frame_start_i,
  input  logic             msb_first_i,
  output logic [WIDTH-1:0] parallel_out_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             busy_o,
`ifdef PARITY_CHECK_EN
  output logic             parity_error_o,
`endif
  output logic             overrun_o
);

`ifdef PARITY_CHECK_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(FrameLen + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             perr_q, perr_d;

  logic             start;
  logic             step;
  logic             complete;
  logic             dir_sel;
  logic [WIDTH-1:0] shreg_shift;
  logic [WIDTH-1:0] shreg_first;
  logic [WIDTH-1:0] word;
  logic             word_perr;

  // A frame_start always wins, even mid-frame: the partial word is simply discarded.
  always_comb begin
    start       = enable_i & frame_start_i;
    step        = enable_i & ~frame_start_i & (state_q == StShift);
    complete    = step & (cnt_q == LastCnt);
    dir_sel     = start ? msb_first_i : dir_q;
    shreg_shift = dir_sel ? {shreg_q[WIDTH-2:0], serial_in_i}
                          : {serial_in_i, shreg_q[WIDTH-1:1]};
    shreg_first = msb_first_i ? {{(WIDTH-1){1'b0}}, serial_in_i}
                              : {serial_in_i, {(WIDTH-1){1'b0}}};
  end

`ifdef PARITY_CHECK_EN
  // The final sampled bit is parity only; the data word is already complete in shreg_q.
  always_comb begin
    word      = shreg_q;
    word_perr = ^{shreg_q, serial_in_i};
  end
`else
  always_comb begin
    word      = shreg_shift;
    word_perr = 1'b0;
  end
`endif

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (start) begin
      shreg_d = shreg_first;
      cnt_d   = OneCnt;
      dir_d   = msb_first_i;
    end else if (step) begin
      if (complete) begin
        cnt_d = '0;
      end else begin
        cnt_d   = cnt_q + OneCnt;
        shreg_d = shreg_shift;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (start) begin
          state_d = StShift;
        end else if (complete) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (state_q == StShift);
  end

  // A completion with the output occupied and not drained this edge drops the new word.
  always_comb begin
    out_d     = out_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    perr_d    = perr_q;
    if (complete) begin
      if (!valid_q || out_ready_i) begin
        out_d   = word;
        perr_d  = word_perr;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b1;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
    end
  end

  always_comb begin
    parallel_out_o = out_q;
    out_valid_o    = valid_q;
    overrun_o      = overrun_q;
  end

`ifdef PARITY_CHECK_EN
  always_comb begin
    parity_error_o = perr_q;
  end
`else
  logic unused_perr;
  always_comb begin
    unused_perr = perr_q ^ word_perr;
  end
`endif

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed self-checking bench for sipo_frame_receiver (WIDTH=8), with or without PARITY_CHECK_EN.
module tb_sipo_frame_receiver;

  localparam int unsigned W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic         serial_in_i;
  logic         frame_start_i;
  logic         msb_first_i;
  logic [W-1:0] parallel_out_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         busy_o;
  logic         overrun_o;
`ifdef PARITY_CHECK_EN
  logic         parity_error_o;
`endif

  int checks   = 0;
  int failures = 0;

  sipo_frame_receiver #(.WIDTH(W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .serial_in_i    (serial_in_i),
    .frame_start_i  (frame_start_i),
    .msb_first_i    (msb_first_i),
    .parallel_out_o (parallel_out_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .busy_o         (busy_o),
`ifdef PARITY_CHECK_EN
    .parity_error_o (parity_error_o),
`endif
    .overrun_o      (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, clock it in, settle 1 time unit past the edge.
  task automatic send_bit(input logic start, input logic b, input logic msb);
    enable_i      = 1'b1;
    frame_start_i = start;
    serial_in_i   = b;
    msb_first_i   = msb;
    @(posedge clk_i);
    #1;
    frame_start_i = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] word, input logic msb, input int first,
                           input int last);
    for (int i = first; i <= last; i++) begin
      send_bit(i == 0, msb ? word[W-1-i] : word[i], msb);
    end
  endtask

  // Final data bit (plus even parity bit when enabled); out_ready only on the completing edge.
  task automatic finish_frame(input logic [W-1:0] word, input logic msb, input logic rdy);
`ifdef PARITY_CHECK_EN
    send_bits(word, msb, W - 1, W - 1);
    out_ready_i = rdy;
    send_bit(1'b0, ^word, msb);
`else
    out_ready_i = rdy;
    send_bits(word, msb, W - 1, W - 1);
`endif
    out_ready_i = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic msb, input logic rdy);
    send_bits(word, msb, 0, W - 2);
    finish_frame(word, msb, rdy);
  endtask

  task automatic idle(input int n, input logic en);
    for (int i = 0; i < n; i++) begin
      enable_i      = en;
      frame_start_i = ~en;
      serial_in_i   = i[0];
      @(posedge clk_i);
      #1;
    end
    enable_i      = 1'b1;
    frame_start_i = 1'b0;
  endtask

  task automatic consume();
    out_ready_i = 1'b1;
    idle(1, 1'b1);
    out_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i         = 1'b1;
    enable_i      = 1'b0;
    serial_in_i   = 1'b0;
    frame_start_i = 1'b0;
    msb_first_i   = 1'b0;
    out_ready_i   = 1'b0;
    #12;
    check("rst_data", parallel_out_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_overrun", overrun_o, 0);
`ifdef PARITY_CHECK_EN
    check("rst_perr", parity_error_o, 0);
`endif
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // MSB-first 1,0,1,0,... -> 8'hAA, held while out_ready=0
    send_bits(8'hAA, 1'b1, 0, W - 2);
    check("msb_mid_busy", busy_o, 1);
    check("msb_mid_valid", out_valid_o, 0);
    finish_frame(8'hAA, 1'b1, 1'b0);
    check("msb_data", parallel_out_o, 8'hAA);
    check("msb_valid", out_valid_o, 1);
    check("msb_busy", busy_o, 0);
    check("msb_overrun", overrun_o, 0);
    idle(2, 1'b1);
    check("hold_data", parallel_out_o, 8'hAA);
    check("hold_valid", out_valid_o, 1);
    consume();
    check("drain_valid", out_valid_o, 0);
    check("drain_data", parallel_out_o, 8'hAA);

    // LSB-first 1,0,1,0,... -> 8'h55
    send_frame(8'h55, 1'b0, 1'b0);
    check("lsb_data", parallel_out_o, 8'h55);
    check("lsb_valid", out_valid_o, 1);
    consume();

    // enable=0 pause after bit 4, inputs toggling
    send_bits(8'hAA, 1'b1, 0, 3);
    idle(3, 1'b0);
    check("pause_busy", busy_o, 1);
    check("pause_valid", out_valid_o, 0);
    send_bits(8'hAA, 1'b1, 4, W - 2);
    check("pause_pre_valid", out_valid_o, 0);
    finish_frame(8'hAA, 1'b1, 1'b0);
    check("pause_data", parallel_out_o, 8'hAA);
    check("pause_valid_end", out_valid_o, 1);
    consume();

    // Back-to-back with output blocked -> second word dropped, overrun sticky
    send_frame(8'hAA, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    check("ovr_data", parallel_out_o, 8'hAA);
    check("ovr_valid", out_valid_o, 1);
    check("ovr_flag", overrun_o, 1);
    idle(2, 1'b1);
    check("ovr_sticky", overrun_o, 1);
    do_reset();
    check("ovr_cleared", overrun_o, 0);

    // Back-to-back with out_ready on the completing edge -> replace, no overrun
    send_frame(8'hAA, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b1);
    check("swap_data", parallel_out_o, 8'h0F);
    check("swap_valid", out_valid_o, 1);
    check("swap_overrun", overrun_o, 0);
    consume();

    // frame_start reasserted at bit 5 -> only 8'h3C delivered
    send_bits(8'hFF, 1'b1, 0, 3);
    send_bits(8'h3C, 1'b1, 0, W - 2);
    check("restart_pre_valid", out_valid_o, 0);
    finish_frame(8'h3C, 1'b1, 1'b0);
    check("restart_data", parallel_out_o, 8'h3C);
    check("restart_valid", out_valid_o, 1);
    check("restart_overrun", overrun_o, 0);

    // Asynchronous reset at bit 3 with out_valid=1
    send_bits(8'h5A, 1'b1, 0, 2);
    check("mid_busy", busy_o, 1);
    #1;
    rst_i = 1'b1;
    #1;
    check("async_data", parallel_out_o, 0);
    check("async_valid", out_valid_o, 0);
    check("async_busy", busy_o, 0);
    check("async_overrun", overrun_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

`ifdef PARITY_CHECK_EN
    send_bits(8'hAA, 1'b1, 0, W - 1);
    check("par_wait_busy", busy_o, 1);
    check("par_wait_valid", out_valid_o, 0);
    send_bit(1'b0, 1'b0, 1'b1);
    check("par0_data", parallel_out_o, 8'hAA);
    check("par0_valid", out_valid_o, 1);
    check("par0_perr", parity_error_o, 0);
    consume();
    send_bits(8'hAA, 1'b1, 0, W - 1);
    send_bit(1'b0, 1'b1, 1'b1);
    check("par1_data", parallel_out_o, 8'hAA);
    check("par1_perr", parity_error_o, 1);
    consume();
    send_bits(8'h01, 1'b1, 0, W - 1);
    send_bit(1'b0, 1'b1, 1'b1);
    check("par01_data", parallel_out_o, 8'h01);
    check("par01_perr", parity_error_o, 0);
    // Dropped frame must not touch parity_error
    send_bits(8'h01, 1'b1, 0, W - 1);
    send_bit(1'b0, 1'b0, 1'b1);
    check("pardrop_overrun", overrun_o, 1);
    check("pardrop_perr", parity_error_o, 0);
    check("pardrop_data", parallel_out_o, 8'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_frame_receiver.md
Name: sipo_frame_receiver

Overview:
- Serial-in/parallel-out frame receiver; the receiving end of the serial link driven by our 8-bit universal shift register used as a PISO transmitter (shift-right/shift-left modes).
- Collects WIDTH serial bits per frame, MSB-first or LSB-first.
- Presents the assembled word on a registered parallel output with a valid/ready handshake toward the downstream datapath.

Parameters:
- WIDTH, 8, data bits per frame; legal range 2..16; bit counter sized internally to hold 0..WIDTH.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  shift enable; 0 freezes frame assembly (shift state, counter, FSM)
- serial_in  input  1  serial data bit, sampled on rising edge when enable=1
- frame_start  input  1  marks that serial_in in this cycle is the first bit of a frame
- msb_first  input  1  1: first bit is MSB (shift left, new bit into LSB); 0: first bit is LSB (shift right, new bit into MSB); sampled with frame_start
- parallel_out  output  WIDTH  received word, stable while out_valid=1
- out_valid  output  1  parallel_out holds an unconsumed word
- out_ready  input  1  downstream accepts word on a clock edge where out_valid=1 and out_ready=1
- busy  output  1  frame in progress (FSM in SHIFT)
- overrun  output  1  sticky: a completed frame was dropped because the output was still occupied

Behaviour:
- Reset: asynchronous. parallel_out=0, out_valid=0, busy=0, overrun=0, shift register=0, bit count=0, FSM=IDLE, direction latch=1.
- FSM states: IDLE, SHIFT.
- IDLE, edge with enable=1 and frame_start=1:
  - latch msb_first;
  - shift serial_in in as bit 1; count=1;
  - go to SHIFT (busy=1 after the edge).
- SHIFT, edge with enable=1:
  - shift serial_in in; count+1.
  - When this edge samples bit WIDTH: transfer the word to the output stage; FSM→IDLE; busy=0.
  - Output latency: out_valid rises on the same edge that samples the final bit.
- frame_start=1 while in SHIFT with enable=1: discard the partial word and restart; the current bit becomes bit 1; count=1; msb_first re-latched. No error flag.
- enable=0:
  - shift register, counter, direction latch and FSM hold;
  - frame_start and serial_in ignored;
  - the output handshake still operates (out_ready can clear out_valid).
- Shift rules: msb_first=1 → shreg = {shreg[WIDTH-2:0], serial_in}; msb_first=0 → shreg = {serial_in, shreg[WIDTH-1:1]}.
- Output stage (on each edge):
  - out_valid=1 & out_ready=1, no completion → out_valid=0; parallel_out keeps its value.
  - Completion while out_valid=0 → load word; out_valid=1.
  - Completion while out_valid=1 & out_ready=1 (same edge) → old word consumed, new word loaded, out_valid stays 1, no overrun.
  - Completion while out_valid=1 & out_ready=0 → new word dropped, old word kept, overrun=1 (sticky until reset).
- Back-to-back frames: frame_start may be asserted in the cycle right after the final bit; no dead cycle required.
- Reset mid-frame or with out_valid=1: everything cleared; the partial frame is lost.

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined:
  - frame is WIDTH+1 bits; the last bit is an even-parity bit over the WIDTH data bits;
  - the parity bit is not shifted into the data word;
  - completion occurs on the edge sampling the parity bit;
  - extra output parity_error (1 bit) is registered with parallel_out and valid while out_valid=1; 1 when XOR(data, parity bit)=1;
  - a dropped frame (overrun) does not update parity_error.
- Undefined: frame is WIDTH bits; the parity_error port does not exist.

Test Plan:
- reset, msb_first=1, frame_start with first bit, stream 1,0,1,0,1,0,1,0, out_ready=0 → parallel_out=8'hAA, out_valid=1 on the 8th sample edge, busy=0, then hold 8'hAA until out_ready=1 (out_valid→0 next edge).
- msb_first=0, stream 1,0,1,0,1,0,1,0 → parallel_out=8'h55.
- MSB-first 8'hAA with enable=0 for 3 cycles after bit 4 (serial_in toggling during the pause) → result still 8'hAA, completion 3 cycles later.
- two back-to-back frames 8'hAA then 8'h0F, out_ready=0 → parallel_out=8'hAA, overrun=1; repeat with out_ready=1 on the second completion edge → parallel_out=8'h0F, overrun=0.
- frame_start reasserted at bit 5 of a frame, then full 8'h3C → only 8'h3C delivered; reset asserted at bit 3 of another frame → all outputs 0 immediately (asynchronous).
- PARITY_CHECK_EN: 8'hAA + parity 0 → parity_error=0; 8'hAA + parity 1 → parity_error=1; 8'h01 + parity 1 → parity_error=0.
